// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC sequencer: FSM states, trap
// cause codes and PC geometry.
package pc_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_EXT      = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } cause_e;

  // Instruction fetch addresses must be word aligned.
  function automatic logic is_misaligned(input logic [PC_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Link between the sequencer and the pcreg program-counter register.
interface pc_sequencer_if;
  import pc_pkg::*;

  logic            pc_ena;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_cur;

  modport master (output pc_ena, output pc_next, input pc_cur);
  modport slave  (input pc_ena, input pc_next, output pc_cur);

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select and branch/jump target alignment check.
module pc_next_mux
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic            trap_take,
  input  logic            eret_take,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] pc_cur,
  input  logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] pc_next,
  output logic            tgt_misalign
);

  // Only the target that would actually be selected is checked; jump outranks branch.
  always_comb begin
    tgt_misalign = 1'b0;
    if (jmp) begin
      tgt_misalign = is_misaligned(jmp_target);
    end else if (br_taken) begin
      tgt_misalign = is_misaligned(br_target);
    end else begin
      tgt_misalign = 1'b0;
    end
  end

  // Priority select; the sequential increment wraps silently at 2^32.
  always_comb begin
    pc_next = pc_cur + PC_STEP;
    if (trap_take) begin
      pc_next = TRAP_VEC;
    end else if (eret_take) begin
      pc_next = epc;
    end else if (jmp) begin
      pc_next = jmp_target;
    end else if (br_taken) begin
      pc_next = br_target;
    end else begin
      pc_next = pc_cur + PC_STEP;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: boot/run/trap FSM, exception PC and cause registers,
// driving pcreg's enable and data input.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  br_taken,
  input  logic [PC_W-1:0]       br_target,
  input  logic                  jmp,
  input  logic [PC_W-1:0]       jmp_target,
  input  logic                  exc,
  input  logic                  eret,
  pc_sequencer_if.master        pc_bus,
  output logic [PC_W-1:0]       epc,
  output logic [1:0]            cause,
  output logic                  in_trap
);

  pc_state_e       state_r, state_nxt_s;
  logic [PC_W-1:0] epc_r, epc_nxt_s;
  cause_e          cause_r, cause_nxt_s;
  logic            trap_take_s, eret_take_s, misalign_s;
  logic            pc_ena_s;
  logic [PC_W-1:0] mux_next_s, pc_next_s;

  // A trap may only be entered from RUN and overrides stall; eret respects stall.
  assign trap_take_s = (state_r == RUN) && (exc || misalign_s);
  assign eret_take_s = (state_r == TRAP) && eret && !stall;

  pc_next_mux #(
    .TRAP_VEC (TRAP_VEC)
  ) u_mux (
    .trap_take    (trap_take_s),
    .eret_take    (eret_take_s),
    .jmp          (jmp),
    .jmp_target   (jmp_target),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .pc_cur       (pc_bus.pc_cur),
    .epc          (epc_r),
    .pc_next      (mux_next_s),
    .tgt_misalign (misalign_s)
  );

  // Next-state, trap bookkeeping and pcreg controls.
  always_comb begin
    state_nxt_s = state_r;
    epc_nxt_s   = epc_r;
    cause_nxt_s = cause_r;
    pc_ena_s    = 1'b0;
    pc_next_s   = RESET_PC;
    if (!rst) begin
      pc_ena_s  = 1'b0;
      pc_next_s = RESET_PC;
    end else begin
      case (state_r)
        BOOT: begin
          pc_ena_s    = 1'b1;
          pc_next_s   = RESET_PC;
          state_nxt_s = RUN;
        end
        RUN: begin
          pc_next_s = mux_next_s;
          if (trap_take_s) begin
            pc_ena_s    = 1'b1;
            epc_nxt_s   = pc_bus.pc_cur;
            cause_nxt_s = exc ? CAUSE_EXT : CAUSE_MISALIGN;
            state_nxt_s = TRAP;
          end else begin
            pc_ena_s = !stall;
          end
        end
        TRAP: begin
          pc_next_s = mux_next_s;
          if (stall) begin
            pc_ena_s = 1'b0;
          end else if (eret_take_s) begin
            pc_ena_s    = 1'b1;
            cause_nxt_s = CAUSE_NONE;
            state_nxt_s = RUN;
          end else if (misalign_s) begin
            // No nested traps: a bad target inside the handler just freezes the PC.
            pc_ena_s = 1'b0;
          end else begin
            pc_ena_s = 1'b1;
          end
        end
        default: begin
          pc_ena_s    = 1'b0;
          pc_next_s   = RESET_PC;
          state_nxt_s = BOOT;
        end
      endcase
    end
  end

  // State and trap registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= BOOT;
      epc_r   <= 32'h0000_0000;
      cause_r <= CAUSE_NONE;
    end else begin
      state_r <= state_nxt_s;
      epc_r   <= epc_nxt_s;
      cause_r <= cause_nxt_s;
    end
  end

  assign pc_bus.pc_ena  = pc_ena_s;
  assign pc_bus.pc_next = pc_next_s;
  assign epc            = epc_r;
  assign cause          = cause_r;
  assign in_trap        = (state_r == TRAP);

endmodule
